// File: rtl/wb_write_queue.sv
// Writeback queue between result producers and the register-file write port.
// In-order FIFO with youngest-match bypass lookup over pending entries.
module wb_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_reg,
    input  logic [31:0] in_data,
    input  logic        wb_hold,
    output logic        regwrite,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    input  logic [4:0]  lookup_reg,
    output logic        lookup_hit,
    output logic [31:0] lookup_data,
    output logic [4:0]  count,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [4:0]    reg_q  [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [4:0]    cnt;
    logic          push;
    logic          pop;

    assign count    = cnt;
    assign full     = (cnt == 5'(DEPTH));
    assign empty    = (cnt == 5'd0);
    assign in_ready = !full && !reset;

    // Register 0 writes complete the handshake but are dropped.
    assign push = in_valid && in_ready && (in_reg != 5'd0);
    // Reset suppresses draining so no strobe escapes in the reset cycle.
    assign pop  = !empty && !wb_hold && !reset;

    // Write port driven straight from the head entry.
    always_comb begin
        regwrite   = 1'b0;
        write_reg  = 5'd0;
        write_data = 32'd0;
        if (pop) begin
            regwrite   = 1'b1;
            write_reg  = reg_q[head];
            write_data = data_q[head];
        end
    end

    // Scan oldest to youngest so the youngest match overrides earlier ones.
    always_comb begin
        logic [AW-1:0] idx;
        lookup_hit  = 1'b0;
        lookup_data = 32'd0;
        idx         = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (!reset && (lookup_reg != 5'd0) && (i < int'(cnt))
                && (reg_q[idx] == lookup_reg)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[idx];
            end
        end
    end

    // Storage, pointers and occupancy update.
    always_ff @(posedge clock) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= 5'd0;
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= 5'd0;
                data_q[i] <= 32'd0;
            end
        end else begin
            if (push) begin
                reg_q[tail]  <= in_reg;
                data_q[tail] <= in_data;
                tail         <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 5'd1;
                2'b01:   cnt <= cnt - 5'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed-vector bench for wb_write_queue.
// Inputs change 1ns after posedge; outputs sampled 1ns later.
module tb_wb_write_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        wb_hold;
    logic        regwrite;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  lookup_reg;
    logic        lookup_hit;
    logic [31:0] lookup_data;
    logic [4:0]  count;
    logic        full;
    logic        empty;

    int n_vec = 0;
    int n_err = 0;

    wb_write_queue #(.DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_reg      (in_reg),
        .in_data     (in_data),
        .wb_hold     (wb_hold),
        .regwrite    (regwrite),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .lookup_reg  (lookup_reg),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_reg     = 5'd0;
        in_data    = 32'd0;
        wb_hold    = 1'b0;
        lookup_reg = 5'd0;
        tick();
        settle();
        chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        settle();
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_wdata", write_data, 32'd0);
        chk("post_rst_hit", {31'd0, lookup_hit}, 32'd0);

        // single write
        in_valid = 1'b1;
        in_reg   = 5'd5;
        in_data  = 32'h0000_00AA;
        tick();
        in_valid   = 1'b0;
        lookup_reg = 5'd5;
        settle();
        chk("single_regwrite", {31'd0, regwrite}, 32'd1);
        chk("single_reg", {27'd0, write_reg}, 32'd5);
        chk("single_data", write_data, 32'h0000_00AA);
        chk("single_count", {27'd0, count}, 32'd1);
        chk("single_head_hit", {31'd0, lookup_hit}, 32'd1);
        chk("single_head_data", lookup_data, 32'h0000_00AA);
        tick();
        settle();
        chk("single_done_rw", {31'd0, regwrite}, 32'd0);
        chk("single_done_empty", {31'd0, empty}, 32'd1);
        chk("single_done_reg", {27'd0, write_reg}, 32'd0);

        // fill under hold
        wb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_reg   = 5'(i);
            in_data  = 32'(i * 'h11);
            tick();
        end
        in_valid = 1'b1;
        in_reg   = 5'd9;
        in_data  = 32'h9999;
        settle();
        chk("fill_count", {27'd0, count}, 32'd4);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_ready", {31'd0, in_ready}, 32'd0);
        chk("fill_held_rw", {31'd0, regwrite}, 32'd0);
        chk("fill_held_data", write_data, 32'd0);
        tick();
        in_valid = 1'b0;
        settle();
        chk("full_stall_count", {27'd0, count}, 32'd4);
        wb_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            settle();
            chk("drain_rw", {31'd0, regwrite}, 32'd1);
            chk("drain_reg", {27'd0, write_reg}, 32'(i));
            chk("drain_data", write_data, 32'(i * 'h11));
            tick();
        end
        settle();
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_rw_off", {31'd0, regwrite}, 32'd0);

        // bypass priority
        wb_hold  = 1'b1;
        in_valid = 1'b1;
        in_reg   = 5'd7;
        in_data  = 32'h100;
        tick();
        in_data = 32'h200;
        tick();
        in_valid   = 1'b0;
        lookup_reg = 5'd7;
        settle();
        chk("byp_hit", {31'd0, lookup_hit}, 32'd1);
        chk("byp_young", lookup_data, 32'h200);
        lookup_reg = 5'd8;
        settle();
        chk("byp_miss_hit", {31'd0, lookup_hit}, 32'd0);
        chk("byp_miss_data", lookup_data, 32'd0);
        wb_hold = 1'b0;
        settle();
        chk("byp_drain0", write_data, 32'h100);
        tick();
        settle();
        chk("byp_drain1", write_data, 32'h200);
        tick();
        settle();
        chk("byp_empty", {31'd0, empty}, 32'd1);

        // register zero
        in_valid = 1'b1;
        in_reg   = 5'd0;
        in_data  = 32'hDEAD;
        settle();
        chk("r0_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid   = 1'b0;
        lookup_reg = 5'd0;
        settle();
        chk("r0_count", {27'd0, count}, 32'd0);
        chk("r0_rw", {31'd0, regwrite}, 32'd0);
        chk("r0_hit", {31'd0, lookup_hit}, 32'd0);

        // streaming with wrap
        wb_hold  = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_reg  = 5'(i + 1);
            in_data = 32'h1000 + 32'(i);
            settle();
            if (i > 0) begin
                chk("strm_rw", {31'd0, regwrite}, 32'd1);
                chk("strm_reg", {27'd0, write_reg}, 32'(i));
                chk("strm_data", write_data, 32'h1000 + 32'(i - 1));
                chk("strm_count", {27'd0, count}, 32'd1);
            end else begin
                chk("strm_count0", {27'd0, count}, 32'd0);
            end
            tick();
        end
        in_valid = 1'b0;
        settle();
        chk("strm_last_reg", {27'd0, write_reg}, 32'd10);
        chk("strm_last_data", write_data, 32'h1009);
        tick();
        settle();
        chk("strm_empty", {31'd0, empty}, 32'd1);

        // reset mid-operation
        wb_hold  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_reg  = 5'(10 + i);
            in_data = 32'hA0 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        settle();
        chk("mid_count", {27'd0, count}, 32'd3);
        reset   = 1'b1;
        wb_hold = 1'b0;
        settle();
        chk("mid_rst_rw", {31'd0, regwrite}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        tick();
        reset      = 1'b0;
        lookup_reg = 5'd10;
        settle();
        chk("mid_post_count", {27'd0, count}, 32'd0);
        chk("mid_post_empty", {31'd0, empty}, 32'd1);
        chk("mid_post_rw", {31'd0, regwrite}, 32'd0);
        chk("mid_post_hit", {31'd0, lookup_hit}, 32'd0);
        tick();
        settle();
        chk("mid_later_rw", {31'd0, regwrite}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
